// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and scan-state encoding for the hex display driver
// Contents: SEG_HEX_0..F active-low segment patterns {g,f,e,d,c,b,a},
//           SEG_OFF / AN_OFF dark values, per-digit anode patterns, digit_e scan states.
package display_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h10;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_DIG0 = 2'b10;
  localparam logic [1:0] AN_DIG1 = 2'b01;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } digit_e;

endpackage

// File: rtl/hex_display_driver_if.sv
// rtl/hex_display_driver_if.sv - capture/blank inputs and 7-segment outputs of the display driver
// Signals: data[7:0], load, blank (toward driver); seg[6:0], dp, an[1:0] (from driver).
// Modports: master = upstream/board side, slave = the driver.
interface hex_display_driver_if;
  logic [7:0] data;
  logic       load;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;

  modport master (output data, load, blank, input seg, dp, an);
  modport slave  (input data, load, blank, output seg, dp, an);
endinterface

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to active-low 7-segment decoder
// Ports: nibble[3:0] in; seg[6:0] out, {g,f,e,d,c,b,a}, active-low.
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hex_display_driver.sv
// rtl/hex_display_driver.sv - two-digit time-multiplexed common-anode hex display driver
// Ports: sysclk (rising edge), rst_n (async assert, active-low),
//        disp.slave: data/load capture, blank, registered seg/an outputs, dp tied off.
// Params: REFRESH_DIV cycles per digit (must be >= 1), BLANK_LEADING darkens a zero high digit.
module hex_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic             sysclk,
  input  logic             rst_n,
  hex_display_driver_if.slave disp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [7:0]       data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  digit_e           digit_q, digit_d;
  logic [6:0]       seg_q,   seg_d;
  logic [1:0]       an_q,    an_d;

  logic             cnt_last;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic             dark;

  // Holding register and refresh counter
  always_comb begin
    data_d   = disp.load ? disp.data : data_q;
    cnt_last = (cnt_q == CNT_LAST);
    cnt_d    = cnt_last ? '0 : cnt_q + CNT_W'(1);
  end

  // Scan FSM next state: flips only on the terminal count
  always_comb begin
    digit_d = digit_q;
    if (cnt_last) begin
      case (digit_q)
        DIG0:    digit_d = DIG1;
        DIG1:    digit_d = DIG0;
        default: digit_d = DIG0;
      endcase
    end
  end

  assign nibble = (digit_q == DIG1) ? data_q[7:4] : data_q[3:0];

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Output register input: built from the current state so a load and a
  // digit toggle on the same edge both show up together one edge later.
  always_comb begin
    dark = disp.blank ||
           (BLANK_LEADING && (digit_q == DIG1) && (data_q[7:4] == 4'h0));
    seg_d = dark ? SEG_OFF : dec_seg;
    an_d  = dark ? AN_OFF : ((digit_q == DIG1) ? AN_DIG1 : AN_DIG0);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      cnt_q   <= '0;
      digit_q <= DIG0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign disp.seg = seg_q;
  assign disp.an  = an_q;
  assign disp.dp  = 1'b1;

endmodule

// File: tb/tb_hex_display_driver.sv
// tb/tb_hex_display_driver.sv - directed self-checking bench for hex_display_driver
module tb_hex_display_driver;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   n      = 0;
  int   tests  = 0;
  int   fails  = 0;

  localparam logic [6:0] TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  always #5 sysclk = ~sysclk;

  // Edges since reset release; the scan phase follows directly from it
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else        n <= n + 1;
  end

  hex_display_driver_if dif ();
  hex_display_driver_if bif ();

  assign bif.data  = dif.data;
  assign bif.load  = dif.load;
  assign bif.blank = dif.blank;

  hex_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .disp   (dif)
  );

  hex_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_bl (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .disp   (bif)
  );

  task automatic tick;
    @(posedge sysclk);
    #1;
  endtask

  // After edge n the displayed digit is the high one in every odd block of 4 edges
  function automatic bit hi_phase();
    return (((n - 1) / 4) % 2) == 1;
  endfunction

  task automatic load_value(input logic [7:0] v);
    dif.data = v;
    dif.load = 1'b1;
    tick;
    dif.load = 1'b0;
  endtask

  task automatic test_reset;
    dif.data = 8'h00; dif.load = 1'b0; dif.blank = 1'b0;
    rst_n = 1'b0;
    tick; tick;
    tests++;
    if (dif.an !== 2'b11 || dif.seg !== 7'h7F || dif.dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_held: an=%b seg=%h dp=%b, expected an=11 seg=7f dp=1", dif.an, dif.seg, dif.dp);
    end
    rst_n = 1'b1;
    tick;
    tests++;
    if (dif.an !== 2'b10 || dif.seg !== 7'h40) begin
      fails++;
      $display("FAIL reset_release: an=%b seg=%h, expected an=10 seg=40", dif.an, dif.seg);
    end
  endtask

  task automatic test_load_scan;
    logic [6:0] es;
    logic [1:0] ea;
    load_value(8'hA5);
    for (int i = 0; i < 16; i++) begin
      tick;
      es = hi_phase() ? 7'h08 : 7'h12;
      ea = hi_phase() ? 2'b01 : 2'b10;
      tests++;
      if (dif.seg !== es || dif.an !== ea || dif.dp !== 1'b1) begin
        fails++;
        $display("FAIL load_scan cyc %0d: seg=%h an=%b dp=%b, expected seg=%h an=%b dp=1", i, dif.seg, dif.an, dif.dp, es, ea);
      end
    end
  endtask

  task automatic test_hold;
    logic [6:0] es;
    load_value(8'h3C);
    dif.data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick;
      es = hi_phase() ? 7'h30 : 7'h46;
      tests++;
      if (dif.seg !== es) begin
        fails++;
        $display("FAIL hold cyc %0d: seg=%h, expected %h", i, dif.seg, es);
      end
    end
  endtask

  task automatic test_full_decode;
    logic [3:0] v;
    logic [1:0] ea;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      load_value({v, v});
      for (int i = 0; i < 8; i++) begin
        tick;
        ea = hi_phase() ? 2'b01 : 2'b10;
        tests++;
        if (dif.seg !== TBL[k] || dif.an !== ea) begin
          fails++;
          $display("FAIL decode %h cyc %0d: seg=%h an=%b, expected seg=%h an=%b", v, i, dif.seg, dif.an, TBL[k], ea);
        end
      end
    end
  endtask

  task automatic test_blank;
    logic [6:0] es;
    logic [1:0] ea;
    load_value(8'h96);
    tick;
    dif.blank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      tests++;
      if (dif.an !== 2'b11 || dif.seg !== 7'h7F) begin
        fails++;
        $display("FAIL blank cyc %0d: an=%b seg=%h, expected an=11 seg=7f", i, dif.an, dif.seg);
      end
    end
    dif.blank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      es = hi_phase() ? 7'h10 : 7'h02;
      ea = hi_phase() ? 2'b01 : 2'b10;
      tests++;
      if (dif.seg !== es || dif.an !== ea) begin
        fails++;
        $display("FAIL blank_resume cyc %0d: seg=%h an=%b, expected seg=%h an=%b", i, dif.seg, dif.an, es, ea);
      end
    end
  endtask

  task automatic test_blank_leading;
    logic [6:0] es, es_bl;
    logic [1:0] ea, ea_bl;
    load_value(8'h07);
    for (int i = 0; i < 8; i++) begin
      tick;
      es_bl = hi_phase() ? 7'h7F  : 7'h78;
      ea_bl = hi_phase() ? 2'b11  : 2'b10;
      es    = hi_phase() ? 7'h40  : 7'h78;
      ea    = hi_phase() ? 2'b01  : 2'b10;
      tests++;
      if (bif.seg !== es_bl || bif.an !== ea_bl) begin
        fails++;
        $display("FAIL blank_leading cyc %0d: seg=%h an=%b, expected seg=%h an=%b", i, bif.seg, bif.an, es_bl, ea_bl);
      end
      tests++;
      if (dif.seg !== es || dif.an !== ea) begin
        fails++;
        $display("FAIL no_blank_leading cyc %0d: seg=%h an=%b, expected seg=%h an=%b", i, dif.seg, dif.an, es, ea);
      end
    end
  endtask

  task automatic test_load_on_terminal;
    for (int i = 0; i < 8 && (n % 8) != 3; i++) tick;
    tests++;
    if ((n % 8) != 3) begin
      fails++;
      $display("FAIL terminal_align: n=%0d, expected n mod 8 = 3", n);
    end
    // Next edge is both the load edge and the DIG0->DIG1 toggle edge
    dif.data = 8'h5A;
    dif.load = 1'b1;
    tick;
    dif.load = 1'b0;
    tests++;
    if (dif.an !== 2'b10) begin
      fails++;
      $display("FAIL terminal_same_edge: an=%b, expected 10", dif.an);
    end
    tick;
    tests++;
    if (dif.seg !== 7'h12 || dif.an !== 2'b01) begin
      fails++;
      $display("FAIL terminal_load: seg=%h an=%b, expected seg=12 an=01", dif.seg, dif.an);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 8 && (n % 8) != 5; i++) tick;
    tests++;
    if (dif.an !== 2'b01) begin
      fails++;
      $display("FAIL reset_mid_pre: an=%b, expected 01", dif.an);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (dif.an !== 2'b11 || dif.seg !== 7'h7F || dif.dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_async: an=%b seg=%h dp=%b, expected an=11 seg=7f dp=1", dif.an, dif.seg, dif.dp);
    end
    tests++;
    if (bif.an !== 2'b11 || bif.seg !== 7'h7F) begin
      fails++;
      $display("FAIL reset_mid_async_bl: an=%b seg=%h, expected an=11 seg=7f", bif.an, bif.seg);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    tests++;
    if (dif.an !== 2'b10 || dif.seg !== 7'h40) begin
      fails++;
      $display("FAIL reset_mid_restart: an=%b seg=%h, expected an=10 seg=40", dif.an, dif.seg);
    end
    tests++;
    if (bif.an !== 2'b10 || bif.seg !== 7'h40) begin
      fails++;
      $display("FAIL reset_mid_restart_bl: an=%b seg=%h, expected an=10 seg=40", bif.an, bif.seg);
    end
  endtask

  initial begin
    test_reset;
    test_load_scan;
    test_hold;
    test_full_decode;
    test_blank;
    test_blank_leading;
    test_load_on_terminal;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
